axis_frame_streamer: RTL
========================

# axis_frame_streamer

Parametrised AXI-Stream frame source. Reads pixels from an external synchronous ROM/BRAM, selects a configurable bit-slice per word, and streams fixed-length frames (default 784 = one 28x28 MNIST image) into the slave port of the accelerator IP. It honours `tready` backpressure and can stream multiple frames with a programmable inter-frame gap and an optional continuous-loop mode. It drives the accelerator in both simulation and on-board self-test.

## Interface
- `TDATA_W`, 32: width of `m_axis_tdata`.
- `MEM_W`, 16: ROM data width.
- `PIX_MSB`, 15: MSB of the pixel slice taken from `rom_dout`.
- `PIX_W`, 8: pixel width. The slice is `rom_dout[PIX_MSB -: PIX_W]`, zero-extended to `TDATA_W`.
- `FRAME_LEN`, 784: beats per frame (≥2).
- `NUM_FRAMES`, 1: frames per run (≥1).
- `GAP_CYCLES`, 0: minimum idle cycles between a frame's last beat and the next frame's first read.
- `ADDR_W`, 10: ROM address width. Must satisfy 2^ADDR_W ≥ FRAME_LEN*NUM_FRAMES.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle start pulse. Sampled only in IDLE.
- `loop_en` in 1: when 1, the block restarts at frame 0 after the last frame. Sampled at each end of run.
- `rom_en` out 1: read enable.
- `rom_addr` out ADDR_W: read address.
- `rom_dout` in MEM_W: read data, valid exactly 1 cycle after `rom_en`.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tdata` out TDATA_W: stream data.
- `m_axis_tlast` out 1: high on the last beat of each frame.
- `m_axis_tready` in 1: stream ready.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse after the final frame's last handshake (suppressed in loop mode).
- `frame_idx` out 16: index of the frame currently being output.

## Operation
- States:
  - IDLE: `start` → FETCH.
  - FETCH: issues reads. After the read for pixel FRAME_LEN-1 of the current frame → DRAIN.
  - DRAIN: waits for the last-beat handshake. Then:
    - → GAP if more frames remain (or `loop_en`=1) and GAP_CYCLES>0;
    - → FETCH directly if more frames remain and GAP_CYCLES=0;
    - → IDLE with `done` pulse otherwise.
  - GAP: counts GAP_CYCLES cycles, then → FETCH.
- Address: `rom_addr = frame*FRAME_LEN + pixel`, held in a running pointer (no multiplier). The pointer resets to 0 at run start and on loop wrap.
- Buffering: a 2-entry output FIFO plus a 1-bit in-flight flag.
  - A read issues in a cycle iff state=FETCH and (occupancy + inflight − pop) < 2, where pop = tvalid & tready.
  - This sustains 1 beat/cycle with tready=1 and never overflows under any tready pattern.
- Each FIFO entry stores {last, pixel}. `last` is set on the entry for pixel FRAME_LEN-1.
- `m_axis_tvalid` = FIFO non-empty. `tdata` and `tlast` come from the FIFO head.
- AXI rules:
  - Once tvalid is asserted, tvalid, tdata and tlast stay stable until tready.
  - tvalid never depends combinationally on tready.
- `frame_idx` increments on each tlast handshake and wraps to 0 at NUM_FRAMES (loop) or on run start.
- `start` is ignored outside IDLE.
- `loop_en` dropping mid-run takes effect at the end of the current run.
- Reset mid-operation: the next cycle state=IDLE, FIFO empty, inflight=0, and all outputs are at reset values. Data of an in-flight read is discarded.

## Timing
- Reset values: tvalid=0, tdata=0, tlast=0, rom_en=0, rom_addr=0, busy=0, done=0, frame_idx=0.
- `start` sampled high at edge E0:
  - `rom_en`=1, `rom_addr`=0 during cycle E0→E1;
  - data captured at E2;
  - first `tvalid` during cycle E2→E3.
- With tready held 1: a frame occupies FRAME_LEN consecutive beats, and the last beat's handshake is at edge E0+2+FRAME_LEN.
- Back-to-back frames with GAP_CYCLES=0: at most 2 idle tvalid cycles between frames (refill latency); no more.
- With GAP: exactly GAP_CYCLES+2 cycles of tvalid=0 between the tlast handshake and the next frame's first tvalid (tready=1).
- `done` is high in the cycle after the final tlast handshake, coincident with `busy` falling.

## Structure
- Shared package `axis_stream_pkg`: state enum (IDLE/FETCH/DRAIN/GAP) and localparam `MNIST_FRAME_LEN` = 784.
- One sub-module: `axis_skid_fifo2` (2-entry FIFO, width PIX_W+1, push/pop/full/empty).
- The top level holds the FSM, address pointer, pixel and frame counters, and in-flight flag.

## Test plan
- Defaults, ROM[i][15:8]=i mod 256, tready=1, single start → 784 beats with tdata=i mod 256, tlast only on beat 784, first tvalid 2 cycles after start, `done` pulse once.
- Random tready (50%) → exactly 784 beats in order, none duplicated. tdata/tlast stable during stalls. ROM never read past address 783.
- NUM_FRAMES=3, GAP_CYCLES=5 → 3 tlasts; tdata continues at address 784 for frame 1. Exactly 7 tvalid-low cycles between frames. frame_idx runs 0,1,2.
- loop_en=1, NUM_FRAMES=2, FRAME_LEN=4 → beats repeat addresses 0..7, 0..7 …, and no `done`. Drop loop_en → `done` after the next frame-1 tlast.
- Assert rst_n=0 mid-frame while tready=0 → next cycle tvalid=0, busy=0. A new start restarts at address 0.
- `start` pulsed during FETCH and GAP → ignored: beat count and addresses unchanged.

Source files
------------

// File: rtl/axis_stream_pkg.sv
// Shared types and constants for the AXI-Stream frame source.
package axis_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        GAP
    } stream_state_e;

    localparam int MNIST_FRAME_LEN = 784;

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry FIFO that holds {last, pixel} between the ROM read port and the stream output.
module axis_skid_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the two entries are reset so the idle output data reads as zero.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: every register update in this block is non-blocking.
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/axis_frame_streamer.sv
// Streams fixed-length pixel frames from a synchronous ROM onto an AXI-Stream master port,
// with optional inter-frame gap and continuous loop mode.
module axis_frame_streamer
    import axis_stream_pkg::*;
#(
    parameter int TDATA_W    = 32,
    parameter int MEM_W      = 16,
    parameter int PIX_MSB    = 15,
    parameter int PIX_W      = 8,
    parameter int FRAME_LEN  = MNIST_FRAME_LEN,
    parameter int NUM_FRAMES = 1,
    parameter int GAP_CYCLES = 0,
    parameter int ADDR_W     = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               loop_en,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [MEM_W-1:0]   rom_dout,
    output logic               m_axis_tvalid,
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    output logic               busy,
    output logic               done,
    output logic [15:0]        frame_idx
);

    localparam int PIX_CNT_W = $clog2(FRAME_LEN);
    localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PIX_CNT_W-1:0] LAST_PIX   = PIX_CNT_W'(FRAME_LEN - 1);
    localparam logic [15:0]          LAST_FRAME = 16'(NUM_FRAMES - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    stream_state_e          state;
    logic [ADDR_W-1:0]      ptr;
    logic [PIX_CNT_W-1:0]   pix_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   inflight;
    logic                   inflight_last;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [PIX_W:0]         head;
    logic [1:0]             occ;
    logic                   pop;
    logic                   issue;
    logic                   last_hs;
    logic                   unused_rom_bits;

    assign occ     = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign pop     = m_axis_tvalid && m_axis_tready;
    assign last_hs = pop && m_axis_tlast;

    // A read may only issue if its data is guaranteed a FIFO slot when it lands.
    always_comb begin
        // NOTE: default first so no path through this block leaves issue unassigned.
        issue = 1'b0;
        if (state == FETCH)
            issue = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            pix_cnt       <= '0;
            gap_cnt       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            frame_idx     <= '0;
            done          <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                inflight_last <= (pix_cnt == LAST_PIX);
                ptr           <= ptr + ADDR_W'(1);
                pix_cnt       <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + PIX_CNT_W'(1);
            end
            if (last_hs)
                frame_idx <= (frame_idx == LAST_FRAME) ? 16'd0 : frame_idx + 16'd1;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        ptr       <= '0;
                        pix_cnt   <= '0;
                        frame_idx <= '0;
                    end
                end
                FETCH: begin
                    if (issue && (pix_cnt == LAST_PIX))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (last_hs) begin
                        if ((frame_idx != LAST_FRAME) || loop_en) begin
                            // Loop wrap restarts the address walk at frame 0.
                            if (frame_idx == LAST_FRAME)
                                ptr <= '0;
                            if (GAP_CYCLES > 0) begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end else begin
                                state <= FETCH;
                            end
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= FETCH;
                    else
                        gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_skid_fifo2 #(
        .W (PIX_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .din   ({inflight_last, rom_dout[PIX_MSB -: PIX_W]}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Only the selected slice of the ROM word carries pixel data.
    assign unused_rom_bits = ^rom_dout;

    assign rom_en        = issue;
    assign rom_addr      = ptr;
    assign busy          = (state != IDLE);
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = TDATA_W'(head[PIX_W-1:0]);
    assign m_axis_tlast  = head[PIX_W];

endmodule
